// File: rtl/rf_dest_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
package rf_dest_arbiter_pkg;

    // Default destination address width (SPARC windowed registers 0..31)
    localparam int ADDR_W_DEF = 5;

    // FSM encodings; the remaining two-bit codes are illegal and recover to idle
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;

    // Requester indices
    localparam logic [1:0] REQ_ALU  = 2'd0;
    localparam logic [1:0] REQ_LD   = 2'd1;
    localparam logic [1:0] REQ_CALL = 2'd2;
    localparam logic [1:0] REQ_WIN  = 2'd3;

    // Round-robin successor of a requester index (wraps 3 -> 0)
    function automatic logic [1:0] ptr_after(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

    // One-hot vector for a requester index
    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rf_dest_arbiter_pick.sv
// Combinational winner picker (round-robin or fixed priority) and the
// 4:1 destination address mux that follows it.
module rr_pick4
    import rf_dest_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic [3:0] mask,
    input  logic       rr_en,
    output logic       valid,
    output logic [1:0] idx,
    output logic [3:0] onehot
);

    logic [3:0] w_elig;
    logic [1:0] w_cand;

    assign w_elig = req & ~mask;

    // Scan from the farthest candidate back to the nearest so the nearest eligible one wins
    always_comb begin
        valid  = 1'b0;
        idx    = 2'd0;
        w_cand = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_cand = rr_en ? (ptr + 2'(k)) : 2'(k);
            if (w_elig[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

    assign onehot = valid ? idx_to_onehot(idx) : 4'b0000;

endmodule

module mux4To1_5
    import rf_dest_arbiter_pkg::*;
#(
    parameter int W = ADDR_W_DEF
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [1:0]   sel,
    output logic [W-1:0] out
);

    // Plain 4:1 select of the requester destination addresses
    always_comb begin
        case (sel)
            REQ_ALU:  out = in0;
            REQ_LD:   out = in1;
            REQ_CALL: out = in2;
            REQ_WIN:  out = in3;
            default:  out = in0;
        endcase
    end

endmodule

// File: rtl/rf_dest_arbiter.sv
// Register-file write-port arbiter: grants one of four requesters, registers
// its destination address and write strobe, and holds the grant until the
// register file accepts the write (r0 writes are dropped immediately).
module rf_dest_arbiter
    import rf_dest_arbiter_pkg::*;
#(
    parameter int   ADDR_W = ADDR_W_DEF,
    parameter logic RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic              wport_ready,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic [ADDR_W-1:0] dest_addr,
    output logic              wr_en,
    output logic              busy
);

    logic [1:0]        r_state;
    logic [1:0]        r_rr_ptr;
    logic [3:0]        r_gnt;
    logic [1:0]        r_sel;
    logic [ADDR_W-1:0] r_dest_addr;
    logic              r_wr_en;
    logic              r_busy;

    logic              w_in_grant;
    logic              w_complete;
    logic              w_abort;
    logic              w_load;
    logic              w_clear;
    logic [1:0]        w_ptr;
    logic [3:0]        w_mask;
    logic              w_valid;
    logic [1:0]        w_idx;
    logic [3:0]        w_onehot;
    logic [ADDR_W-1:0] w_pick_addr;

    // A grant ends when the write is accepted or when it targets r0 (discarded).
    // On that edge the search restarts just past the finishing requester and
    // skips it, so the new grant lands with no idle cycle in between.
    always_comb begin
        w_in_grant = (r_state == ST_GRANT);
        w_complete = w_in_grant && (wport_ready || (r_dest_addr == '0));
        w_abort    = w_in_grant && !w_complete && !req[r_sel];
        w_ptr      = w_complete ? ptr_after(r_sel) : r_rr_ptr;
        w_mask     = w_complete ? idx_to_onehot(r_sel) : 4'b0000;
        w_load     = w_valid && ((r_state == ST_IDLE) || w_complete);
        w_clear    = !w_load && (w_complete || w_abort ||
                     ((r_state != ST_IDLE) && (r_state != ST_GRANT)));
    end

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (w_ptr),
        .mask   (w_mask),
        .rr_en  (RR_EN),
        .valid  (w_valid),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    mux4To1_5 #(.W(ADDR_W)) u_addr_mux (
        .in0 (addr0),
        .in1 (addr1),
        .in2 (addr2),
        .in3 (addr3),
        .sel (w_idx),
        .out (w_pick_addr)
    );

    // Round-robin pointer only advances when a write completes, never on abort
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= 2'd0;
        end else if (w_complete) begin
            r_rr_ptr <= ptr_after(r_sel);
        end
    end

    // FSM and output registers: load a new grant, clear to idle, or hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 4'b0000;
            r_sel       <= 2'd0;
            r_dest_addr <= '0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_load) begin
            r_state     <= ST_GRANT;
            r_gnt       <= w_onehot;
            r_sel       <= w_idx;
            r_dest_addr <= w_pick_addr;
            r_wr_en     <= (w_pick_addr != '0);
            r_busy      <= 1'b1;
        end else if (w_clear) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 4'b0000;
            r_sel       <= 2'd0;
            r_dest_addr <= '0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign dest_addr = r_dest_addr;
    assign wr_en     = r_wr_en;
    assign busy      = r_busy;

endmodule

// File: tb/tb_rf_dest_arbiter.sv
// Bench for rf_dest_arbiter: a round-robin and a fixed-priority instance
// share one stimulus stream; both are compared every cycle against a
// behavioural model, plus directed scenarios with literal expectations.
module tb_rf_dest_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [4:0] addr [4];
    logic       ready = 1'b0;

    logic [3:0] gnt_rr, gnt_fp;
    logic [1:0] sel_rr, sel_fp;
    logic [4:0] dest_rr, dest_fp;
    logic       wr_rr, wr_fp;
    logic       busy_rr, busy_fp;

    int errors = 0;
    int checks = 0;

    // Model state per instance (0 = round-robin, 1 = fixed priority):
    // granted requester index (-1 when idle), latched address, search pointer
    int         m_gi   [2];
    logic [4:0] m_dest [2];
    int         m_ptr  [2];

    always #5 clk = ~clk;

    rf_dest_arbiter #(.ADDR_W(5), .RR_EN(1'b1)) dut_rr (
        .clk(clk), .reset_n(reset_n), .req(req),
        .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]), .addr3(addr[3]),
        .wport_ready(ready), .gnt(gnt_rr), .sel(sel_rr), .dest_addr(dest_rr),
        .wr_en(wr_rr), .busy(busy_rr)
    );

    rf_dest_arbiter #(.ADDR_W(5), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset_n(reset_n), .req(req),
        .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]), .addr3(addr[3]),
        .wport_ready(ready), .gnt(gnt_fp), .sel(sel_fp), .dest_addr(dest_fp),
        .wr_en(wr_fp), .busy(busy_fp)
    );

    // First requesting index in search order, skipping 'excl'; -1 if none
    function automatic int pick(input logic [3:0] r, input int start, input int excl, input bit rr);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = rr ? ((start + k) % 4) : k;
            if (r[i] && (i != excl)) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int m, input bit rr);
        int w;
        int c;
        if (m_gi[m] < 0) begin
            w = pick(req, m_ptr[m], -1, rr);
            if (w >= 0) begin
                m_gi[m] = w; m_dest[m] = addr[w];
            end
        end else if (ready || (m_dest[m] == 5'd0)) begin
            c = m_gi[m];
            m_ptr[m] = (c + 1) % 4;
            w = pick(req, m_ptr[m], c, rr);
            if (w >= 0) begin
                m_gi[m] = w; m_dest[m] = addr[w];
            end else begin
                m_gi[m] = -1; m_dest[m] = 5'd0;
            end
        end else if (!req[m_gi[m]]) begin
            m_gi[m] = -1; m_dest[m] = 5'd0;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < 2; m++) begin
                m_gi[m] = -1; m_dest[m] = 5'd0; m_ptr[m] = 0;
            end
        end else begin
            model_step(0, 1'b1);
            model_step(1, 1'b0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int eg;
        for (int m = 0; m < 2; m++) begin
            eg = (m_gi[m] < 0) ? 0 : (1 << m_gi[m]);
            if (m == 0) begin
                chk("rr.gnt",  int'(gnt_rr),  eg);
                chk("rr.sel",  int'(sel_rr),  (m_gi[m] < 0) ? 0 : m_gi[m]);
                chk("rr.dest", int'(dest_rr), int'(m_dest[m]));
                chk("rr.wr_en", int'(wr_rr),  int'(m_dest[m] != 5'd0));
                chk("rr.busy", int'(busy_rr), int'(m_gi[m] >= 0));
            end else begin
                chk("fp.gnt",  int'(gnt_fp),  eg);
                chk("fp.sel",  int'(sel_fp),  (m_gi[m] < 0) ? 0 : m_gi[m]);
                chk("fp.dest", int'(dest_fp), int'(m_dest[m]));
                chk("fp.wr_en", int'(wr_fp),  int'(m_dest[m] != 5'd0));
                chk("fp.busy", int'(busy_fp), int'(m_gi[m] >= 0));
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic chk_rr_zero(input string tag);
        chk({tag, ".gnt"},  int'(gnt_rr),  0);
        chk({tag, ".sel"},  int'(sel_rr),  0);
        chk({tag, ".dest"}, int'(dest_rr), 0);
        chk({tag, ".wr_en"}, int'(wr_rr),  0);
        chk({tag, ".busy"}, int'(busy_rr), 0);
    endtask

    initial begin
        int exp2 [4];
        exp2[0] = 2; exp2[1] = 4; exp2[2] = 8; exp2[3] = 1;
        for (int i = 0; i < 4; i++) addr[i] = 5'd0;

        // Power-on reset
        repeat (3) cycle();
        chk_rr_zero("reset");
        reset_n = 1'b1;

        // Reset asserted mid-grant clears outputs without waiting for a clock
        req = 4'b0010; addr[1] = 5'd7;
        cycle();
        chk("t1.pre_gnt", int'(gnt_rr), 2);
        #2 reset_n = 1'b0;
        #1 compare_all();
        chk_rr_zero("t1.async");
        cycle();
        reset_n = 1'b1;
        req = 4'b1111;
        addr[0] = 5'd1; addr[1] = 5'd2; addr[2] = 5'd3; addr[3] = 5'd4;
        ready = 1'b1;
        cycle();
        chk("t1.gnt", int'(gnt_rr), 1);
        chk("t1.sel", int'(sel_rr), 0);

        // Round-robin rotation with no idle cycle between grants
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t2.gnt", int'(gnt_rr), exp2[i]);
        end
        req = 4'b0000;
        cycle();
        chk("t2.idle_gnt", int'(gnt_rr), 0);
        chk("t2.idle_busy", int'(busy_rr), 0);
        ready = 1'b0;

        // Stalled write holds the grant until accepted
        req = 4'b0100; addr[2] = 5'd15;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t3.gnt", int'(gnt_rr), 4);
            chk("t3.sel", int'(sel_rr), 2);
            chk("t3.dest", int'(dest_rr), 15);
            chk("t3.wr_en", int'(wr_rr), 1);
        end
        ready = 1'b1;
        cycle();
        chk("t3.done_gnt", int'(gnt_rr), 0);
        req = 4'b0000; ready = 1'b0;

        // r0 destination: one-cycle grant without write strobe
        req = 4'b0010; addr[1] = 5'd0;
        cycle();
        chk("t4.gnt", int'(gnt_rr), 2);
        chk("t4.wr_en", int'(wr_rr), 0);
        req = 4'b0000;
        cycle();
        chk("t4.idle_gnt", int'(gnt_rr), 0);
        chk("t4.idle_busy", int'(busy_rr), 0);

        // Abort leaves the pointer where it was
        req = 4'b1000; addr[3] = 5'd9;
        cycle();
        chk("t5.gnt", int'(gnt_rr), 8);
        req = 4'b0000;
        cycle();
        chk("t5.abort_gnt", int'(gnt_rr), 0);
        chk("t5.abort_busy", int'(busy_rr), 0);
        req = 4'b1001; addr[0] = 5'd4;
        cycle();
        chk("t5.regnt", int'(gnt_rr), 8);
        chk("t5.dest", int'(dest_rr), 9);
        req = 4'b0001; ready = 1'b1;
        cycle();
        chk("t5.b2b_gnt", int'(gnt_rr), 1);
        chk("t5.b2b_dest", int'(dest_rr), 4);
        req = 4'b0000;
        cycle();
        chk("t5.end_gnt", int'(gnt_rr), 0);
        ready = 1'b0;

        // Fixed priority: lower index always wins from idle
        addr[1] = 5'd6; addr[3] = 5'd10;
        for (int r = 0; r < 3; r++) begin
            req = 4'b1010;
            cycle();
            chk("t6.gnt", int'(gnt_fp), 2);
            req = 4'b0000;
            cycle();
            chk("t6.idle", int'(gnt_fp), 0);
        end

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
                if ($urandom_range(0, 3) == 0)
                    addr[b] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            end
            ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_n = 1'b0;
                #1 compare_all();
                cycle();
                reset_n = 1'b1;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
